// File: rtl/controle_jogo_if.sv
// Signal bundle between the naval-game sequencer, its map selector and the player's controls.
interface controle_jogo_if;
    logic [2:0] chave_mapa;
    logic       confirmar;
    logic [2:0] linha;
    logic [2:0] coluna;
    logic       atacar;
    logic [6:0] mapa0;
    logic [6:0] mapa1;
    logic [6:0] mapa2;
    logic [6:0] mapa3;
    logic [6:0] mapa4;
    logic [2:0] sel_mapa;
    logic [4:0] saida_linhas;
    logic [6:0] saida_colunas;
    logic [5:0] acertos;
    logic [5:0] tentativas;
    logic       venceu;
    logic       perdeu;

    modport master (
        output chave_mapa, confirmar, linha, coluna, atacar,
        output mapa0, mapa1, mapa2, mapa3, mapa4,
        input  sel_mapa, saida_linhas, saida_colunas, acertos, tentativas, venceu, perdeu
    );

    modport slave (
        input  chave_mapa, confirmar, linha, coluna, atacar,
        input  mapa0, mapa1, mapa2, mapa3, mapa4,
        output sel_mapa, saida_linhas, saida_colunas, acertos, tentativas, venceu, perdeu
    );
endinterface

// File: rtl/controle_jogo.sv
// Naval-game sequencer for a 5x7 LED matrix: map choice, shot tracking, win/loss and row scan.
// Optional macro PREVIA_MAPA_EN previews the selected map on the matrix while choosing.
module controle_jogo #(
    parameter int DIV            = 4,
    parameter int MAX_TENTATIVAS = 20
) (
    input  logic           clk,
    input  logic           reset,
    controle_jogo_if.slave bus
);
    typedef enum logic [1:0] {SELECAO, JOGO, VITORIA, DERROTA} estado_t;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    estado_t       r_estado, w_prox;
    logic [2:0]    r_sel;
    logic [34:0]   r_mask;
    logic [5:0]    r_acertos, r_tent, r_total;
    logic          r_venceu, r_perdeu;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_linha;
    logic [4:0]    r_linhas;
    logic [6:0]    r_colunas;

    logic [5:0] w_total, w_idx, w_acertos_novo, w_tent_novo;
    logic [6:0] w_mapa_atk, w_mapa_scan, w_mask_scan, w_dado;
    logic [2:0] w_linha_prox;
    logic       w_coord_ok, w_ja_atirado, w_acerto, w_aceito, w_limpa;

    assign w_total      = 6'($countones({bus.mapa0, bus.mapa1, bus.mapa2, bus.mapa3, bus.mapa4}));
    assign w_coord_ok   = (bus.linha <= 3'd4) && (bus.coluna <= 3'd6);
    // Mask uses the map's own layout: row r occupies bits 7r+6..7r, column 0 at the top.
    assign w_idx        = 6'(bus.linha) * 6'd7 + 6'(3'd6 - bus.coluna);
    assign w_ja_atirado = w_coord_ok ? r_mask[w_idx] : 1'b1;
    assign w_aceito     = (r_estado == JOGO) && bus.atacar && !w_ja_atirado;
    assign w_acertos_novo = r_acertos + {5'd0, w_acerto};
    assign w_tent_novo    = r_tent + 6'd1;
    assign w_limpa        = bus.confirmar && (r_estado != JOGO);
    assign w_linha_prox   = (r_linha == 3'd4) ? 3'd0 : r_linha + 3'd1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_mapa_atk = '0;
        w_acerto   = 1'b0;
        case (bus.linha)
            3'd0:    w_mapa_atk = bus.mapa0;
            3'd1:    w_mapa_atk = bus.mapa1;
            3'd2:    w_mapa_atk = bus.mapa2;
            3'd3:    w_mapa_atk = bus.mapa3;
            3'd4:    w_mapa_atk = bus.mapa4;
            default: w_mapa_atk = '0;
        endcase
        if (w_coord_ok) w_acerto = w_mapa_atk[3'd6 - bus.coluna];
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            SELECAO: if (bus.confirmar) w_prox = (w_total == 6'd0) ? VITORIA : JOGO;
            JOGO: begin
                if (w_aceito) begin
                    if (w_acertos_novo == r_total)                  w_prox = VITORIA;
                    else if (w_tent_novo == 6'(MAX_TENTATIVAS))     w_prox = DERROTA;
                end
            end
            VITORIA, DERROTA: if (bus.confirmar) w_prox = SELECAO;
            default: w_prox = SELECAO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_estado <= SELECAO;
        else       r_estado <= w_prox;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel     <= '0;
            r_mask    <= '0;
            r_acertos <= '0;
            r_tent    <= '0;
            r_total   <= '0;
            r_venceu  <= 1'b0;
            r_perdeu  <= 1'b0;
        end else begin
            r_venceu <= (w_prox == VITORIA);
            r_perdeu <= (w_prox == DERROTA);
            if (r_estado == SELECAO && !bus.confirmar) r_sel   <= bus.chave_mapa;
            if (r_estado == SELECAO &&  bus.confirmar) r_total <= w_total;
            if (w_limpa) begin
                r_mask    <= '0;
                r_acertos <= '0;
                r_tent    <= '0;
            end else if (w_aceito) begin
                r_mask[w_idx] <= 1'b1;
                r_acertos     <= w_acertos_novo;
                r_tent        <= w_tent_novo;
            end
        end
    end

    // Column data is chosen for the row about to be shown, so it changes together with the row enable.
    always_comb begin
        w_mapa_scan = '0;
        w_mask_scan = '0;
        w_dado      = '0;
        case (w_linha_prox)
            3'd0:    begin w_mapa_scan = bus.mapa0; w_mask_scan = r_mask[6:0];   end
            3'd1:    begin w_mapa_scan = bus.mapa1; w_mask_scan = r_mask[13:7];  end
            3'd2:    begin w_mapa_scan = bus.mapa2; w_mask_scan = r_mask[20:14]; end
            3'd3:    begin w_mapa_scan = bus.mapa3; w_mask_scan = r_mask[27:21]; end
            3'd4:    begin w_mapa_scan = bus.mapa4; w_mask_scan = r_mask[34:28]; end
            default: begin w_mapa_scan = '0;        w_mask_scan = '0;            end
        endcase
        case (r_estado)
            JOGO:             w_dado = w_mask_scan;
            VITORIA, DERROTA: w_dado = w_mapa_scan;
`ifdef PREVIA_MAPA_EN
            SELECAO:          w_dado = w_mapa_scan;
`else
            SELECAO:          w_dado = '0;
`endif
            default:          w_dado = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc   <= '0;
            r_linha   <= '0;
            r_linhas  <= 5'b00001;
            r_colunas <= '0;
        end else if (r_presc == PW'(DIV - 1)) begin
            r_presc   <= '0;
            r_linha   <= w_linha_prox;
            r_linhas  <= 5'b00001 << w_linha_prox;
            r_colunas <= w_dado;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign bus.sel_mapa      = r_sel;
    assign bus.saida_linhas  = r_linhas;
    assign bus.saida_colunas = r_colunas;
    assign bus.acertos       = r_acertos;
    assign bus.tentativas    = r_tent;
    assign bus.venceu        = r_venceu;
    assign bus.perdeu        = r_perdeu;
endmodule
